mii_frame_checker: RTL and testbench

Downstream consumer of the 66b-to-MII decode stage in the BASE-R verification chain. Takes the 64-bit MII word and 8-bit control vector produced by that stage, one word per valid cycle. Delimits Ethernet frames between /S/ and /T/ and checks the preamble, SFD, payload fill pattern, inter-frame idles and frame length. Keeps per-frame and per-word error counters for end-of-test reporting.

---
 rtl/mii_frame_checker.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mii_frame_checker.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_frame_checker.sv
// mii_frame_checker
//   Checks the 64-bit MII word stream coming out of the 66b-to-MII decoder.
//   Frames are delimited by a start word (/S/ + preamble + SFD) and a /T/.
//   Each closed frame reports its payload length and status. Running
//   counters collect frame, error and ordered-set statistics.
//
// Ports
//   clk                 rising-edge clock
//   i_rst               synchronous reset, active low
//   i_valid             qualifies i_rxd / i_rxc
//   i_rxd               MII data, lane k = bits [8k+7:8k], lane 0 first
//   i_rxc               MII control, bit k set = lane k is a control char
//   o_frame_done        one-cycle pulse when a frame closes
//   o_frame_ok          status of the last closed frame
//   o_frame_len         payload length of the last closed frame
//   o_frame_count       frames closed
//   o_good_frame_count  frames closed without error
//   o_bad_frame_count   frames closed with an error
//   o_len_err_count     frames closed with a length outside [MIN, MAX]
//   o_inv_char_count    valid words holding at least one illegal character
//   o_oset_count        /Q/ ordered-set words seen between frames
module mii_frame_checker #(
   parameter int         DATA_WIDTH        = 64,
   parameter int         CTRL_WIDTH        = DATA_WIDTH / 8,
   parameter logic [7:0] DATA_CHAR_PATTERN = 8'hAA,
   parameter int         MIN_FRAME_LEN     = 64,
   parameter int         MAX_FRAME_LEN     = 1518
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_rxd,
   input  logic [CTRL_WIDTH-1:0] i_rxc,
   output logic                  o_frame_done,
   output logic                  o_frame_ok,
   output logic [15:0]           o_frame_len,
   output logic [31:0]           o_frame_count,
   output logic [31:0]           o_good_frame_count,
   output logic [31:0]           o_bad_frame_count,
   output logic [31:0]           o_len_err_count,
   output logic [31:0]           o_inv_char_count,
   output logic [31:0]           o_oset_count
);

   localparam int LANE_W = $clog2(CTRL_WIDTH);

   localparam logic [7:0] CH_IDLE  = 8'h07;
   localparam logic [7:0] CH_START = 8'hFB;
   localparam logic [7:0] CH_TERM  = 8'hFD;
   localparam logic [7:0] CH_OSET  = 8'h9C;
   localparam logic [7:0] CH_PRE   = 8'h55;
   localparam logic [7:0] CH_SFD   = 8'hD5;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FRAME = 1'b1
   } state_t;

   // per-lane decode
   logic [7:0]            lane [CTRL_WIDTH];
   logic [CTRL_WIDTH-1:0] lane_is_pat;
   logic [CTRL_WIDTH-1:0] lane_is_idle;
   logic [CTRL_WIDTH-1:0] lane_is_start;
   logic [CTRL_WIDTH-1:0] below_mask;
   logic [CTRL_WIDTH-1:0] above_mask;
   logic [LANE_W-1:0]     ctrl_lane;

   logic word_idle;
   logic word_oset;
   logic word_start;
   logic word_all_pat;
   logic term_here;
   logic below_ok;
   logic above_ok;

   // state
   state_t      state_reg, state_next;
   logic [15:0] len_reg, len_next;
   logic        err_reg, err_next;
   logic        frame_done_reg, frame_done_next;
   logic        frame_ok_reg, frame_ok_next;
   logic [15:0] frame_len_reg, frame_len_next;
   logic [31:0] frame_count_reg, frame_count_next;
   logic [31:0] good_count_reg, good_count_next;
   logic [31:0] bad_count_reg, bad_count_next;
   logic [31:0] len_err_count_reg, len_err_count_next;
   logic [31:0] inv_count_reg, inv_count_next;
   logic [31:0] oset_count_reg, oset_count_next;

   // per-word decisions
   logic        close_frame;
   logic        close_err;
   logic [15:0] close_len;
   logic        close_len_err;
   logic        inv_word;
   logic        tail_bad;

   genvar gi;
   generate
      for (gi = 0; gi < CTRL_WIDTH; gi++) begin : g_lane
         assign lane[gi]         = i_rxd[8*gi +: 8];
         assign lane_is_pat[gi]  = !i_rxc[gi] && (lane[gi] == DATA_CHAR_PATTERN);
         assign lane_is_idle[gi] = i_rxc[gi] && (lane[gi] == CH_IDLE);
         // lanes strictly before / after the first control lane
         assign below_mask[gi]   = (LANE_W'(gi) < ctrl_lane);
         assign above_mask[gi]   = (LANE_W'(gi) > ctrl_lane);
         if (gi == 0) begin : g_sop
            assign lane_is_start[gi] = i_rxc[gi] && (lane[gi] == CH_START);
         end else if (gi == CTRL_WIDTH - 1) begin : g_sfd
            assign lane_is_start[gi] = !i_rxc[gi] && (lane[gi] == CH_SFD);
         end else begin : g_pre
            assign lane_is_start[gi] = !i_rxc[gi] && (lane[gi] == CH_PRE);
         end
      end
   endgenerate

   // Lowest lane carrying a control character; only meaningful when i_rxc != 0.
   always_comb begin
      ctrl_lane = '0;
      for (int i = CTRL_WIDTH - 1; i >= 0; i--) begin
         if (i_rxc[i]) begin
            ctrl_lane = LANE_W'(i);
         end
      end
   end

   assign word_idle    = &lane_is_idle;
   assign word_start   = &lane_is_start;
   assign word_all_pat = &lane_is_pat;
   assign word_oset    = (i_rxc == CTRL_WIDTH'(1)) && (lane[0] == CH_OSET);
   assign term_here    = (lane[ctrl_lane] == CH_TERM);
   assign below_ok     = &(lane_is_pat | ~below_mask);
   assign above_ok     = &(lane_is_idle | ~above_mask);

   // Length never wraps: a runaway frame pins at 0xFFFF.
   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   assign close_len_err = (close_len < 16'(MIN_FRAME_LEN)) || (close_len > 16'(MAX_FRAME_LEN));

   always_comb begin
      state_next         = state_reg;
      len_next           = len_reg;
      err_next           = err_reg;
      frame_done_next    = 1'b0;
      frame_ok_next      = frame_ok_reg;
      frame_len_next     = frame_len_reg;
      frame_count_next   = frame_count_reg;
      good_count_next    = good_count_reg;
      bad_count_next     = bad_count_reg;
      len_err_count_next = len_err_count_reg;
      inv_count_next     = inv_count_reg;
      oset_count_next    = oset_count_reg;
      close_frame        = 1'b0;
      close_err          = 1'b0;
      close_len          = len_reg;
      inv_word           = 1'b0;
      tail_bad           = 1'b0;

      if (i_valid) begin
         if (state_reg == ST_IDLE) begin
            if (word_idle) begin
               // inter-frame fill, nothing to do
            end else if (word_oset) begin
               oset_count_next = oset_count_reg + 32'd1;
            end else if (word_start) begin
               state_next = ST_FRAME;
               len_next   = '0;
               err_next   = 1'b0;
            end else begin
               inv_word = 1'b1;
            end
         end else begin
            if (word_start) begin
               // truncated frame: close as bad and reopen from this start word
               close_frame = 1'b1;
               close_err   = 1'b1;
               len_next    = '0;
               err_next    = 1'b0;
            end else if (i_rxc == '0) begin
               len_next = sat_add(len_reg, 16'd8);
               if (!word_all_pat) begin
                  inv_word = 1'b1;
                  err_next = 1'b1;
               end
            end else if (term_here) begin
               tail_bad    = !(below_ok && above_ok);
               inv_word    = tail_bad;
               close_frame = 1'b1;
               close_err   = err_reg || tail_bad;
               close_len   = sat_add(len_reg, 16'(ctrl_lane));
               state_next  = ST_IDLE;
               len_next    = '0;
               err_next    = 1'b0;
            end else begin
               inv_word = 1'b1;
               err_next = 1'b1;
               len_next = sat_add(len_reg, 16'(ctrl_lane));
            end
         end
      end

      if (close_frame) begin
         frame_done_next  = 1'b1;
         frame_ok_next    = !close_err && !close_len_err;
         frame_len_next   = close_len;
         frame_count_next = frame_count_reg + 32'd1;
         if (!close_err && !close_len_err) begin
            good_count_next = good_count_reg + 32'd1;
         end else begin
            bad_count_next = bad_count_reg + 32'd1;
         end
         if (close_len_err) begin
            len_err_count_next = len_err_count_reg + 32'd1;
         end
      end

      if (inv_word) begin
         inv_count_next = inv_count_reg + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!i_rst) begin
         state_reg         <= ST_IDLE;
         len_reg           <= '0;
         err_reg           <= 1'b0;
         frame_done_reg    <= 1'b0;
         frame_ok_reg      <= 1'b0;
         frame_len_reg     <= '0;
         frame_count_reg   <= '0;
         good_count_reg    <= '0;
         bad_count_reg     <= '0;
         len_err_count_reg <= '0;
         inv_count_reg     <= '0;
         oset_count_reg    <= '0;
      end else begin
         state_reg         <= state_next;
         len_reg           <= len_next;
         err_reg           <= err_next;
         frame_done_reg    <= frame_done_next;
         frame_ok_reg      <= frame_ok_next;
         frame_len_reg     <= frame_len_next;
         frame_count_reg   <= frame_count_next;
         good_count_reg    <= good_count_next;
         bad_count_reg     <= bad_count_next;
         len_err_count_reg <= len_err_count_next;
         inv_count_reg     <= inv_count_next;
         oset_count_reg    <= oset_count_next;
      end
   end

   assign o_frame_done       = frame_done_reg;
   assign o_frame_ok         = frame_ok_reg;
   assign o_frame_len        = frame_len_reg;
   assign o_frame_count      = frame_count_reg;
   assign o_good_frame_count = good_count_reg;
   assign o_bad_frame_count  = bad_count_reg;
   assign o_len_err_count    = len_err_count_reg;
   assign o_inv_char_count   = inv_count_reg;
   assign o_oset_count       = oset_count_reg;

endmodule

// File: tb/tb_mii_frame_checker.sv
// tb_mii_frame_checker
//   Self-checking bench for mii_frame_checker: a table of directed word
//   vectors with expected outputs, hand-written boundary sequences, and a
//   randomized stream compared against a byte-level reference model.
`timescale 1ns/1ps
module tb_mii_frame_checker;

   localparam logic [63:0] IDLE_D   = 64'h0707070707070707;
   localparam logic [63:0] START_D  = 64'hD5555555555555FB;
   localparam logic [63:0] PAT_D    = 64'hAAAAAAAAAAAAAAAA;
   localparam logic [63:0] TERM0_D  = 64'h07070707070707FD;
   localparam logic [63:0] TERM3_D  = 64'h07070707FDAAAAAA;
   localparam logic [63:0] Q_D      = 64'h000000000000009C;
   localparam logic [63:0] SL4_D    = 64'h555555FB07070707;
   localparam logic [63:0] BADPAT_D = 64'hAAAAABAAAAAAAAAA;
   localparam logic [63:0] EWORD_D  = 64'hAAAAAAAAAAFEAAAA;

   logic        clk;
   logic        i_rst;
   logic        i_valid;
   logic [63:0] i_rxd;
   logic [7:0]  i_rxc;
   logic        o_frame_done;
   logic        o_frame_ok;
   logic [15:0] o_frame_len;
   logic [31:0] o_frame_count;
   logic [31:0] o_good_frame_count;
   logic [31:0] o_bad_frame_count;
   logic [31:0] o_len_err_count;
   logic [31:0] o_inv_char_count;
   logic [31:0] o_oset_count;

   mii_frame_checker dut (
      .clk                (clk),
      .i_rst              (i_rst),
      .i_valid            (i_valid),
      .i_rxd              (i_rxd),
      .i_rxc              (i_rxc),
      .o_frame_done       (o_frame_done),
      .o_frame_ok         (o_frame_ok),
      .o_frame_len        (o_frame_len),
      .o_frame_count      (o_frame_count),
      .o_good_frame_count (o_good_frame_count),
      .o_bad_frame_count  (o_bad_frame_count),
      .o_len_err_count    (o_len_err_count),
      .o_inv_char_count   (o_inv_char_count),
      .o_oset_count       (o_oset_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model (byte-level view of the rules) ----------------
   bit          m_in_frame;
   int          m_len;
   bit          m_err;
   bit          m_done;
   bit          m_ok;
   logic [15:0] m_flen;
   bit   [31:0] m_frames, m_good, m_bad, m_lenerr, m_inv, m_oset;

   task automatic model_reset();
      m_in_frame = 0; m_len = 0; m_err = 0; m_done = 0; m_ok = 0; m_flen = '0;
      m_frames = 0; m_good = 0; m_bad = 0; m_lenerr = 0; m_inv = 0; m_oset = 0;
   endtask

   task automatic model_close(input bit had_err);
      bit lerr;
      lerr     = (m_len < 64) || (m_len > 1518);
      m_done   = 1;
      m_ok     = !had_err && !lerr;
      m_flen   = 16'(m_len);
      m_frames = m_frames + 1;
      if (m_ok) m_good = m_good + 1;
      else      m_bad  = m_bad + 1;
      if (lerr) m_lenerr = m_lenerr + 1;
   endtask

   task automatic model_word(input logic v, input logic [63:0] d, input logic [7:0] c);
      logic [7:0] b [8];
      bit all_idle, is_start, bad, is_term;
      int k;
      m_done = 0;
      if (!v) return;
      for (int i = 0; i < 8; i++) b[i] = d[8*i +: 8];
      all_idle = 1;
      for (int i = 0; i < 8; i++) if (!(c[i] && b[i] == 8'h07)) all_idle = 0;
      is_start = (c == 8'h01) && (b[0] == 8'hFB) && (b[7] == 8'hD5);
      for (int i = 1; i < 7; i++) if (b[i] != 8'h55) is_start = 0;
      if (!m_in_frame) begin
         if (all_idle) begin
         end else if (c == 8'h01 && b[0] == 8'h9C) begin
            m_oset = m_oset + 1;
         end else if (is_start) begin
            m_in_frame = 1; m_len = 0; m_err = 0;
         end else begin
            m_inv = m_inv + 1;
         end
      end else if (is_start) begin
         model_close(1'b1);
         m_len = 0; m_err = 0;
      end else begin
         k = 8;
         for (int i = 7; i >= 0; i--) if (c[i]) k = i;
         bad = 0;
         for (int i = 0; i < k; i++) if (b[i] != 8'hAA) bad = 1;
         is_term = 0;
         if (k == 8) begin
            m_len += 8;
         end else begin
            m_len += k;
            is_term = (b[k] == 8'hFD);
            if (is_term) begin
               for (int i = k + 1; i < 8; i++) if (!(c[i] && b[i] == 8'h07)) bad = 1;
            end else begin
               bad = 1;
            end
         end
         if (m_len > 65535) m_len = 65535;
         if (bad) begin m_inv = m_inv + 1; m_err = 1; end
         if (is_term) begin
            model_close(m_err);
            m_in_frame = 0;
         end
      end
   endtask

   task automatic check_model();
      chk("frame_done", 32'(o_frame_done), 32'(m_done));
      chk("frame_ok", 32'(o_frame_ok), 32'(m_ok));
      chk("frame_len", 32'(o_frame_len), 32'(m_flen));
      chk("frame_count", o_frame_count, m_frames);
      chk("good_count", o_good_frame_count, m_good);
      chk("bad_count", o_bad_frame_count, m_bad);
      chk("len_err_count", o_len_err_count, m_lenerr);
      chk("inv_char_count", o_inv_char_count, m_inv);
      chk("oset_count", o_oset_count, m_oset);
   endtask

   // ---------------- drivers ----------------
   task automatic cycle(input logic v, input logic [63:0] d, input logic [7:0] c);
      i_valid = v; i_rxd = d; i_rxc = c;
      @(posedge clk);
      #1;
      model_word(v, d, c);
   endtask

   task automatic run(input logic v, input logic [63:0] d, input logic [7:0] c);
      cycle(v, d, c);
      check_model();
      if (m_done)
         $display("frame %0d closed: len=%0d ok=%0b (dut len=%0d ok=%0b)",
                  m_frames, m_flen, m_ok, o_frame_len, o_frame_ok);
   endtask

   task automatic do_reset();
      i_rst = 1'b0; i_valid = 1'b1; i_rxd = START_D; i_rxc = 8'h01;
      @(posedge clk);
      #1;
      i_rst = 1'b1;
      model_reset();
      check_model();
      $display("reset applied");
   endtask

   function automatic logic [71:0] term_word(input int k, input bit corrupt);
      logic [63:0] d;
      logic [7:0]  c;
      int j;
      d = '0; c = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < k)       d[8*i +: 8] = 8'hAA;
         else if (i == k) begin d[8*i +: 8] = 8'hFD; c[i] = 1'b1; end
         else             begin d[8*i +: 8] = 8'h07; c[i] = 1'b1; end
      end
      if (corrupt && k < 7) begin
         j = int'($urandom_range(7, k + 1));
         d[8*j +: 8] = 8'h00;
         c[j] = 1'b0;
      end
      return {c, d};
   endfunction

   task automatic frame_of(input int nwords, input int k);
      logic [71:0] t;
      run(1, START_D, 8'h01);
      for (int i = 0; i < nwords; i++) cycle(1, PAT_D, 8'h00);
      check_model();
      t = term_word(k, 1'b0);
      run(1, t[63:0], t[71:64]);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        valid;
      logic [63:0] d;
      logic [7:0]  c;
      logic        done;
      logic        ok;
      logic [15:0] len;
      logic [31:0] frames, good, bad, lenerr, inv, oset;
   } vec_t;

   vec_t        tbl [$];
   logic        e_ok;
   logic [15:0] e_len;
   logic [31:0] e_fr, e_gd, e_bd, e_le, e_inv, e_os;

   task automatic add_row(input logic v, input logic [63:0] d, input logic [7:0] c, input logic done);
      vec_t r;
      r.valid = v; r.d = d; r.c = c; r.done = done; r.ok = e_ok; r.len = e_len;
      r.frames = e_fr; r.good = e_gd; r.bad = e_bd; r.lenerr = e_le; r.inv = e_inv; r.oset = e_os;
      tbl.push_back(r);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [71:0] t;
      logic [63:0] rd;
      logic [7:0]  x;
      int          r, n, j;

      i_rst = 1'b0; i_valid = 1'b0; i_rxd = '0; i_rxc = '0;

      // ---- table fill ----
      e_ok = 0; e_len = 0; e_fr = 0; e_gd = 0; e_bd = 0; e_le = 0; e_inv = 0; e_os = 0;
      add_row(1, IDLE_D, 8'hFF, 0);
      e_os = 1;  add_row(1, Q_D, 8'h01, 0);
      e_inv = 1; add_row(1, TERM0_D, 8'hFF, 0);
      e_inv = 2; add_row(1, SL4_D, 8'h1F, 0);
      add_row(0, START_D, 8'h01, 0);
      // good 64-byte frame
      add_row(1, START_D, 8'h01, 0);
      for (int i = 0; i < 8; i++) add_row(1, PAT_D, 8'h00, 0);
      e_ok = 1; e_len = 64; e_fr = 1; e_gd = 1;
      add_row(1, TERM0_D, 8'hFF, 1);
      add_row(1, IDLE_D, 8'hFF, 0);
      // 59-byte frame, /T/ in lane 3
      add_row(1, START_D, 8'h01, 0);
      for (int i = 0; i < 7; i++) add_row(1, PAT_D, 8'h00, 0);
      e_ok = 0; e_len = 59; e_fr = 2; e_bd = 1; e_le = 1;
      add_row(1, TERM3_D, 8'hF8, 1);
      // 64-byte frame with one corrupted payload byte
      add_row(1, START_D, 8'h01, 0);
      add_row(1, PAT_D, 8'h00, 0);
      add_row(1, PAT_D, 8'h00, 0);
      e_inv = 3; add_row(1, BADPAT_D, 8'h00, 0);
      for (int i = 0; i < 5; i++) add_row(1, PAT_D, 8'h00, 0);
      e_len = 64; e_fr = 3; e_bd = 2;
      add_row(1, TERM0_D, 8'hFF, 1);
      // truncated frame followed by a good one
      add_row(1, START_D, 8'h01, 0);
      for (int i = 0; i < 4; i++) add_row(1, PAT_D, 8'h00, 0);
      e_len = 32; e_fr = 4; e_bd = 3; e_le = 2;
      add_row(1, START_D, 8'h01, 1);
      for (int i = 0; i < 8; i++) add_row(1, PAT_D, 8'h00, 0);
      e_ok = 1; e_len = 64; e_fr = 5; e_gd = 2;
      add_row(1, TERM0_D, 8'hFF, 1);

      // ---- reset ----
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      chk("reset frame_done", 32'(o_frame_done), 32'd0);
      chk("reset frame_count", o_frame_count, 32'd0);
      chk("reset inv_char", o_inv_char_count, 32'd0);
      i_rst = 1'b1;

      // ---- table ----
      for (int i = 0; i < tbl.size(); i++) begin
         cycle(tbl[i].valid, tbl[i].d, tbl[i].c);
         $display("vec %0d: valid=%0b rxc=%02h done=%0b ok=%0b len=%0d frames=%0d inv=%0d",
                  i, tbl[i].valid, tbl[i].c, o_frame_done, o_frame_ok, o_frame_len,
                  o_frame_count, o_inv_char_count);
         chk($sformatf("vec%0d frame_done", i), 32'(o_frame_done), 32'(tbl[i].done));
         chk($sformatf("vec%0d frame_ok", i), 32'(o_frame_ok), 32'(tbl[i].ok));
         chk($sformatf("vec%0d frame_len", i), 32'(o_frame_len), 32'(tbl[i].len));
         chk($sformatf("vec%0d frame_count", i), o_frame_count, tbl[i].frames);
         chk($sformatf("vec%0d good", i), o_good_frame_count, tbl[i].good);
         chk($sformatf("vec%0d bad", i), o_bad_frame_count, tbl[i].bad);
         chk($sformatf("vec%0d len_err", i), o_len_err_count, tbl[i].lenerr);
         chk($sformatf("vec%0d inv_char", i), o_inv_char_count, tbl[i].inv);
         chk($sformatf("vec%0d oset", i), o_oset_count, tbl[i].oset);
      end

      // ---- reset mid-frame, then a good frame with valid gaps ----
      run(1, START_D, 8'h01);
      for (int i = 0; i < 3; i++) run(1, PAT_D, 8'h00);
      do_reset();
      chk("rst frame_count", o_frame_count, 32'd0);
      chk("rst bad_count", o_bad_frame_count, 32'd0);
      chk("rst inv_char", o_inv_char_count, 32'd0);
      chk("rst oset", o_oset_count, 32'd0);
      chk("rst frame_len", 32'(o_frame_len), 32'd0);
      run(1, START_D, 8'h01);
      for (int i = 0; i < 4; i++) run(1, PAT_D, 8'h00);
      for (int i = 0; i < 3; i++) begin
         run(0, START_D, 8'h01);
         chk("gap frame_done", 32'(o_frame_done), 32'd0);
         chk("gap frame_count", o_frame_count, 32'd0);
      end
      for (int i = 0; i < 4; i++) run(1, PAT_D, 8'h00);
      run(1, TERM0_D, 8'hFF);
      chk("gap frame_len", 32'(o_frame_len), 32'd64);
      chk("gap frame_ok", 32'(o_frame_ok), 32'd1);
      chk("gap frame_count", o_frame_count, 32'd1);
      chk("gap good", o_good_frame_count, 32'd1);
      run(1, IDLE_D, 8'hFF);
      chk("pulse one cycle", 32'(o_frame_done), 32'd0);

      // ---- length boundaries ----
      frame_of(189, 6);
      chk("max len", 32'(o_frame_len), 32'd1518);
      chk("max ok", 32'(o_frame_ok), 32'd1);
      frame_of(189, 7);
      chk("max+1 len", 32'(o_frame_len), 32'd1519);
      chk("max+1 ok", 32'(o_frame_ok), 32'd0);
      frame_of(7, 7);
      chk("min-1 len", 32'(o_frame_len), 32'd63);
      chk("min-1 ok", 32'(o_frame_ok), 32'd0);
      frame_of(8192, 3);
      chk("sat len", 32'(o_frame_len), 32'hFFFF);
      chk("sat ok", 32'(o_frame_ok), 32'd0);

      // ---- /E/ inside a frame ----
      run(1, START_D, 8'h01);
      for (int i = 0; i < 8; i++) run(1, PAT_D, 8'h00);
      run(1, EWORD_D, 8'h04);
      run(1, TERM0_D, 8'hFF);
      chk("E len", 32'(o_frame_len), 32'd66);
      chk("E ok", 32'(o_frame_ok), 32'd0);

      // ---- randomized stream ----
      for (int f = 0; f < 250; f++) begin
         if ($urandom_range(99, 0) == 0) do_reset();
         n = int'($urandom_range(3, 0));
         for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(99, 0));
            rd = {$urandom, $urandom};
            if (r < 10)      run(0, rd, 8'($urandom));
            else if (r < 20) run(1, {rd[63:8], 8'h9C}, 8'h01);
            else if (r < 25) run(1, rd, 8'($urandom));
            else             run(1, IDLE_D, 8'hFF);
         end
         run(1, START_D, 8'h01);
         r = int'($urandom_range(99, 0));
         if (r < 10)      n = int'($urandom_range(192, 185));
         else if (r < 25) n = int'($urandom_range(3, 0));
         else             n = int'($urandom_range(10, 5));
         for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(99, 0));
            j = int'($urandom_range(7, 0));
            if (r < 8) begin
               run(0, {$urandom, $urandom}, 8'($urandom));
            end else if (r < 11) begin
               x = 8'($urandom);
               if (x == 8'hAA) x = 8'h00;
               rd = PAT_D;
               rd[8*j +: 8] = x;
               run(1, rd, 8'h00);
            end else if (r < 13) begin
               rd = PAT_D;
               rd[8*j +: 8] = 8'hFE;
               run(1, rd, 8'(1 << j));
            end else if (r < 15) begin
               run(1, START_D, 8'h01);
            end else begin
               run(1, PAT_D, 8'h00);
            end
         end
         r = int'($urandom_range(99, 0));
         if (r >= 5) begin
            t = term_word(int'($urandom_range(7, 0)), r < 15);
            run(1, t[63:0], t[71:64]);
         end
      end
      run(1, IDLE_D, 8'hFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
